// File: rtl/uart_tx_arb.sv
// ---------------------------------------------------------------------------
// uart_tx_arb
//   Two-requester arbiter in front of a byte-wide UART transmitter. Unlocked
//   traffic is served round-robin; a requester may hold ownership across
//   several bytes with its lock input, bounded by LOCK_MAX consecutive bytes.
//
// Ports
//   clk, resetq                 clock, synchronous active-low reset
//   reqN_valid/data/lock        requester N byte offer and lock request
//   reqN_ready                  byte accepted from requester N this cycle
//   uart_wr, uart_dat           one-cycle write strobe and byte to the UART
//   uart_busy                   UART busy, rises the cycle after uart_wr
//   grant                       one-hot current owner, 2'b00 when none
// ---------------------------------------------------------------------------
module uart_tx_arb #(
   parameter int LOCK_MAX = 16
) (
   input  logic       clk,
   input  logic       resetq,
   input  logic       req0_valid,
   input  logic [7:0] req0_data,
   input  logic       req0_lock,
   output logic       req0_ready,
   input  logic       req1_valid,
   input  logic [7:0] req1_data,
   input  logic       req1_lock,
   output logic       req1_ready,
   output logic       uart_wr,
   output logic [7:0] uart_dat,
   input  logic       uart_busy,
   output logic [1:0] grant
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ISSUE  = 2'd1,
      S_SETTLE = 2'd2,
      S_WAIT   = 2'd3
   } state_t;

   localparam logic [7:0] LMAX = 8'(LOCK_MAX);

   state_t     r_state;
   state_t     w_state_nxt;
   logic [7:0] r_dat;
   logic [1:0] r_grant;
   logic       r_ptr;       // last-served requester
   logic       r_lock;      // ownership is being held across bytes
   logic [7:0] r_lock_cnt;

   logic       w_owner;
   logic       w_owner_lock;
   logic       w_hold;
   logic       w_open;
   logic       w_cand;
   logic       w_sel;
   logic       w_acc;
   logic       w_lock_in;
   logic [7:0] w_dat_in;
   logic [7:0] w_cnt_nxt;

   // ---------------------------------------------------------------------
   // Selection: a held lock restricts the choice to the owner; the owner
   // dropping its lock releases it immediately so round-robin applies in
   // the same cycle.
   // ---------------------------------------------------------------------
   always_comb begin
      w_owner      = r_grant[1];
      w_owner_lock = w_owner ? req1_lock : req0_lock;
      w_hold       = r_lock & w_owner_lock;
      // resetq gates acceptance so nothing is taken while reset is held
      w_open       = (r_state == S_IDLE) & ~uart_busy & resetq;
      if (w_hold) begin
         w_sel  = w_owner;
         w_cand = w_owner ? req1_valid : req0_valid;
      end else if (req0_valid & req1_valid) begin
         w_sel  = ~r_ptr;
         w_cand = 1'b1;
      end else begin
         w_sel  = req1_valid;
         w_cand = req0_valid | req1_valid;
      end
      w_acc     = w_open & w_cand;
      w_lock_in = w_sel ? req1_lock : req0_lock;
      w_dat_in  = w_sel ? req1_data : req0_data;
      // continuing ownership counts up and saturates; a fresh one starts at 1
      if (!w_hold)
         w_cnt_nxt = 8'd1;
      else if (r_lock_cnt >= LMAX)
         w_cnt_nxt = LMAX;
      else
         w_cnt_nxt = r_lock_cnt + 8'd1;
   end

   // ---------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!resetq)
         r_state <= S_IDLE;
      else
         r_state <= w_state_nxt;
   end

   // ---------------------------------------------------------------------
   // FSM: next state. SETTLE covers the cycle before uart_busy is valid.
   // ---------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:   if (w_acc) w_state_nxt = S_ISSUE;
         S_ISSUE:  w_state_nxt = S_SETTLE;
         S_SETTLE: w_state_nxt = S_WAIT;
         S_WAIT:   if (!uart_busy) w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------
   // FSM: outputs
   // ---------------------------------------------------------------------
   always_comb begin
      req0_ready = w_acc & ~w_sel;
      req1_ready = w_acc &  w_sel;
      uart_wr    = (r_state == S_ISSUE);
      uart_dat   = r_dat;
      grant      = r_grant;
   end

   // ---------------------------------------------------------------------
   // Ownership, pointer, lock counter and data register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!resetq) begin
         r_dat      <= 8'h00;
         r_grant    <= 2'b00;
         r_ptr      <= 1'b1;   // pointer at 1 so requester 0 wins a tie
         r_lock     <= 1'b0;
         r_lock_cnt <= 8'd0;
      end else begin
         if (r_state == S_IDLE) begin
            if (w_acc) begin
               r_dat      <= w_dat_in;
               r_grant    <= w_sel ? 2'b10 : 2'b01;
               r_ptr      <= w_sel;
               r_lock_cnt <= w_cnt_nxt;
               // reaching LOCK_MAX forces release at the end of this byte
               r_lock     <= w_lock_in & (w_cnt_nxt < LMAX);
            end else if (r_lock & ~w_owner_lock) begin
               r_grant    <= 2'b00;
               r_lock     <= 1'b0;
               r_lock_cnt <= 8'd0;
            end
         end
         if ((r_state == S_WAIT) && !uart_busy && !r_lock) begin
            r_grant    <= 2'b00;
            r_lock_cnt <= 8'd0;
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_arb.sv
module tb_uart_tx_arb;
   localparam int FRAME = 10;

   logic       clk = 1'b0;
   logic       resetq = 1'b0;
   logic       req0_valid = 1'b0, req0_lock = 1'b0, req1_valid = 1'b0, req1_lock = 1'b0;
   logic [7:0] req0_data = 8'h00, req1_data = 8'h00;
   logic       req0_ready, req1_ready, uart_wr, uart_busy;
   logic [7:0] uart_dat;
   logic [1:0] grant;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int bcnt = 0;
   int dly = 0;
   logic slow = 1'b0;
   int viol = 0;
   logic [7:0] log_dat[$];
   logic [1:0] log_gnt[$];
   int         log_cyc[$];

   uart_tx_arb #(.LOCK_MAX(4)) dut (
      .clk(clk), .resetq(resetq),
      .req0_valid(req0_valid), .req0_data(req0_data), .req0_lock(req0_lock), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_data(req1_data), .req1_lock(req1_lock), .req1_ready(req1_ready),
      .uart_wr(uart_wr), .uart_dat(uart_dat), .uart_busy(uart_busy), .grant(grant)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // UART model: busy for FRAME cycles starting the cycle after uart_wr;
   // slow mode keeps busy low for 3 cycles before the frame starts.
   assign uart_busy = (bcnt != 0);
   always @(posedge clk) begin
      if (!resetq) begin
         bcnt <= 0;
         dly  <= 0;
      end else if (uart_wr) begin
         if (slow) dly <= 3;
         else      bcnt <= FRAME;
      end else if (dly > 1) begin
         dly <= dly - 1;
      end else if (dly == 1) begin
         dly  <= 0;
         bcnt <= FRAME;
      end else if (bcnt != 0) begin
         bcnt <= bcnt - 1;
      end
   end

   always @(negedge clk) begin
      if (uart_wr) begin
         log_dat.push_back(uart_dat);
         log_gnt.push_back(grant);
         log_cyc.push_back(cyc);
         if (uart_busy) viol++;
      end
   end

   task automatic do_reset();
      @(negedge clk);
      resetq = 1'b0; slow = 1'b0;
      req0_valid = 0; req0_lock = 0; req1_valid = 0; req1_lock = 0;
      @(negedge clk);
      resetq = 1'b1;
      log_dat.delete(); log_gnt.delete(); log_cyc.delete(); viol = 0;
   endtask

   task automatic test_reset();
      resetq = 1'b0; req0_valid = 1; req0_data = 8'hFF; req1_valid = 1; req1_data = 8'hEE;
      repeat (2) @(negedge clk);
      #1;
      n_cmp++; if (uart_wr !== 1'b0) begin n_err++; $display("FAIL reset_wr: got %b want 0", uart_wr); end
      n_cmp++; if (uart_dat !== 8'h00) begin n_err++; $display("FAIL reset_dat: got %h want 00", uart_dat); end
      n_cmp++; if ({req0_ready, req1_ready} !== 2'b00) begin n_err++; $display("FAIL reset_ready: got %b want 00", {req0_ready, req1_ready}); end
      n_cmp++; if (grant !== 2'b00) begin n_err++; $display("FAIL reset_grant: got %b want 00", grant); end
      n_cmp++; if (dut.r_lock_cnt !== 8'd0) begin n_err++; $display("FAIL reset_lockcnt: got %0d want 0", dut.r_lock_cnt); end
      n_cmp++; if (dut.r_state !== 2'd0) begin n_err++; $display("FAIL reset_state: got %0d want 0", dut.r_state); end
      @(negedge clk);
      resetq = 1'b1;
      #1;
      n_cmp++; if ({req0_ready, req1_ready} !== 2'b10) begin n_err++; $display("FAIL reset_ptr: got %b want 10", {req0_ready, req1_ready}); end
      req0_valid = 0; req1_valid = 0;
      @(negedge clk); #1;
      n_cmp++; if ({uart_wr, grant} !== 3'b000) begin n_err++; $display("FAIL reset_noaccept: got %b want 000", {uart_wr, grant}); end
   endtask

   task automatic test_single();
      do_reset();
      @(negedge clk);
      req0_valid = 1; req0_data = 8'hA5; req0_lock = 0;
      #1;
      n_cmp++; if ({req0_ready, req1_ready} !== 2'b10) begin n_err++; $display("FAIL single_ready: got %b want 10", {req0_ready, req1_ready}); end
      @(negedge clk);
      req0_valid = 0;
      #1;
      n_cmp++; if ({uart_wr, uart_dat, grant} !== {1'b1, 8'hA5, 2'b01}) begin n_err++; $display("FAIL single_strobe: got %b/%h/%b want 1/a5/01", uart_wr, uart_dat, grant); end
      for (int k = 2; k <= 12; k++) begin
         @(negedge clk); #1;
         n_cmp++; if ({uart_wr, grant} !== 3'b001) begin n_err++; $display("FAIL single_hold T+%0d: got %b want 001", k, {uart_wr, grant}); end
      end
      @(negedge clk); #1;
      n_cmp++; if ({dut.r_state, grant} !== 4'b0000) begin n_err++; $display("FAIL single_release: got %b want 0000", {dut.r_state, grant}); end
      n_cmp++; if (log_dat.size() !== 1) begin n_err++; $display("FAIL single_count: got %0d want 1", log_dat.size()); end
   endtask

   task automatic test_contention();
      logic [7:0] exp_d[4];
      logic [1:0] exp_g[4];
      exp_d = '{8'h11, 8'h22, 8'h11, 8'h22};
      exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
      do_reset();
      req0_valid = 1; req0_data = 8'h11; req1_valid = 1; req1_data = 8'h22;
      for (int c = 0; c < 200 && log_dat.size() < 4; c++) begin
         @(negedge clk); #1;
      end
      req0_valid = 0; req1_valid = 0;
      n_cmp++;
      if (log_dat.size() < 4) begin
         n_err++; $display("FAIL cont_timeout: got %0d strobes want 4", log_dat.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            n_cmp++; if ({log_dat[i], log_gnt[i]} !== {exp_d[i], exp_g[i]}) begin n_err++; $display("FAIL cont_order[%0d]: got %h/%b want %h/%b", i, log_dat[i], log_gnt[i], exp_d[i], exp_g[i]); end
         end
         for (int i = 0; i < 3; i++) begin
            n_cmp++; if (log_cyc[i+1] - log_cyc[i] !== FRAME + 3) begin n_err++; $display("FAIL cont_gap[%0d]: got %0d want %0d", i, log_cyc[i+1] - log_cyc[i], FRAME + 3); end
         end
      end
      n_cmp++; if (viol !== 0) begin n_err++; $display("FAIL cont_busy_strobe: got %0d want 0", viol); end
   endtask

   task automatic test_lock();
      int idx = 0;
      int gcnt = 100;
      int early = 0;
      logic done3 = 1'b0;
      logic [7:0] exp_d[4];
      logic [1:0] exp_g[4];
      exp_d = '{8'hB1, 8'hB2, 8'hB3, 8'h55};
      exp_g = '{2'b10, 2'b10, 2'b10, 2'b01};
      do_reset();
      for (int c = 0; c < 400 && log_dat.size() < 4; c++) begin
         @(negedge clk);
         if (idx == 3 && !done3) begin
            done3 = 1'b1;
            n_cmp++; if (dut.r_lock_cnt !== 8'd3) begin n_err++; $display("FAIL lock_cnt3: got %0d want 3", dut.r_lock_cnt); end
         end
         req1_data  = 8'hB1 + 8'(idx);
         req1_valid = (idx < 3) && !(idx == 2 && gcnt < 20);
         req1_lock  = (idx < 3);
         req0_valid = (idx >= 1); req0_data = 8'h55; req0_lock = 0;
         #1;
         if (req0_ready && idx < 3) early++;
         if (req1_ready) begin
            idx++;
            if (idx == 2) gcnt = 0;
         end
         gcnt++;
      end
      req0_valid = 0; req1_valid = 0; req1_lock = 0;
      n_cmp++; if (early !== 0) begin n_err++; $display("FAIL lock_gap_ready: got %0d want 0", early); end
      n_cmp++;
      if (log_dat.size() < 4) begin
         n_err++; $display("FAIL lock_timeout: got %0d strobes want 4", log_dat.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            n_cmp++; if ({log_dat[i], log_gnt[i]} !== {exp_d[i], exp_g[i]}) begin n_err++; $display("FAIL lock_order[%0d]: got %h/%b want %h/%b", i, log_dat[i], log_gnt[i], exp_d[i], exp_g[i]); end
         end
      end
   endtask

   task automatic test_forced();
      int idx0 = 0;
      logic [7:0] exp_d[6];
      logic [1:0] exp_g[6];
      exp_d = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'h77, 8'hA4};
      exp_g = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01};
      do_reset();
      for (int c = 0; c < 600 && log_dat.size() < 6; c++) begin
         @(negedge clk);
         req0_valid = 1; req0_lock = 1; req0_data = 8'hA0 + 8'(idx0);
         req1_valid = 1; req1_lock = 0; req1_data = 8'h77;
         #1;
         if (req0_ready) idx0++;
      end
      n_cmp++;
      if (log_dat.size() < 6) begin
         n_err++; $display("FAIL forced_timeout: got %0d strobes want 6", log_dat.size());
      end else begin
         n_cmp++; if (dut.r_lock_cnt !== 8'd1) begin n_err++; $display("FAIL forced_cnt: got %0d want 1", dut.r_lock_cnt); end
         for (int i = 0; i < 6; i++) begin
            n_cmp++; if ({log_dat[i], log_gnt[i]} !== {exp_d[i], exp_g[i]}) begin n_err++; $display("FAIL forced_order[%0d]: got %h/%b want %h/%b", i, log_dat[i], log_gnt[i], exp_d[i], exp_g[i]); end
         end
      end
      req0_valid = 0; req0_lock = 0; req1_valid = 0;
   endtask

   task automatic test_reset_mid();
      do_reset();
      @(negedge clk);
      req0_valid = 1; req0_data = 8'h5A; req0_lock = 0;
      @(negedge clk); req0_valid = 0;
      @(negedge clk);
      @(negedge clk); #1;
      n_cmp++; if (dut.r_state !== 2'd3) begin n_err++; $display("FAIL mid_inwait: got %0d want 3", dut.r_state); end
      resetq = 0; req1_valid = 1; req1_data = 8'h66; req1_lock = 0;
      @(negedge clk); #1;
      n_cmp++; if ({uart_wr, uart_dat, grant, req0_ready, req1_ready} !== 13'd0) begin n_err++; $display("FAIL mid_outputs: got %b/%h/%b/%b%b want all 0", uart_wr, uart_dat, grant, req0_ready, req1_ready); end
      n_cmp++; if (dut.r_state !== 2'd0) begin n_err++; $display("FAIL mid_state: got %0d want 0", dut.r_state); end
      resetq = 1;
      log_dat.delete(); log_gnt.delete(); log_cyc.delete();
      #1;
      n_cmp++; if ({req0_ready, req1_ready} !== 2'b01) begin n_err++; $display("FAIL mid_req1_first: got %b want 01", {req0_ready, req1_ready}); end
      @(negedge clk); req1_valid = 0;
      repeat (20) @(negedge clk);
      #1;
      n_cmp++; if (log_dat.size() !== 1 || log_dat[0] !== 8'h66) begin n_err++; $display("FAIL mid_log: got %0d strobes first %h want 1 strobe 66", log_dat.size(), (log_dat.size() > 0) ? log_dat[0] : 8'h00); end
      resetq = 0; req0_valid = 1; req0_data = 8'h0F; req1_valid = 1; req1_data = 8'hF0;
      @(negedge clk);
      resetq = 1;
      #1;
      n_cmp++; if ({req0_ready, req1_ready} !== 2'b10) begin n_err++; $display("FAIL mid_both: got %b want 10", {req0_ready, req1_ready}); end
      req0_valid = 0; req1_valid = 0;
   endtask

   task automatic test_settle();
      do_reset();
      slow = 1;
      @(negedge clk);
      req0_valid = 1; req0_data = 8'h3C; req0_lock = 0;
      #1;
      n_cmp++; if (req0_ready !== 1'b1) begin n_err++; $display("FAIL settle_ready: got %b want 1", req0_ready); end
      @(negedge clk); req0_valid = 0; #1;
      n_cmp++; if ({uart_wr, dut.r_state} !== 3'b101) begin n_err++; $display("FAIL settle_issue: got %b want 101", {uart_wr, dut.r_state}); end
      @(negedge clk); #1;
      n_cmp++; if ({uart_wr, dut.r_state} !== 3'b010) begin n_err++; $display("FAIL settle_settle: got %b want 010", {uart_wr, dut.r_state}); end
      @(negedge clk); #1;
      n_cmp++; if ({uart_wr, dut.r_state} !== 3'b011) begin n_err++; $display("FAIL settle_wait: got %b want 011", {uart_wr, dut.r_state}); end
      @(negedge clk); #1;
      n_cmp++; if ({dut.r_state, grant} !== 4'b0000) begin n_err++; $display("FAIL settle_idle: got %b want 0000", {dut.r_state, grant}); end
      @(negedge clk);
      req1_valid = 1; req1_data = 8'h99;
      #1;
      n_cmp++; if ({uart_busy, req1_ready} !== 2'b10) begin n_err++; $display("FAIL settle_busy_block: got %b want 10", {uart_busy, req1_ready}); end
      req1_valid = 0;
      repeat (15) @(negedge clk);
      #1;
      n_cmp++; if (log_dat.size() !== 1 || viol !== 0) begin n_err++; $display("FAIL settle_single_strobe: got %0d strobes %0d viol want 1/0", log_dat.size(), viol); end
      slow = 0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_lock();
      test_forced();
      test_reset_mid();
      test_settle();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 Parameter LOCK_MAX, default 16: maximum consecutive bytes one requester may send under lock before a forced release; legal range 1..255.
REQ-002 clk  input  1  single clock; all logic on posedge.
REQ-003 resetq  input  1  reset; synchronous and active-low.
REQ-004 req0_valid  input  1  requester 0 has a byte on req0_data.
REQ-005 req0_data  input  8  requester 0 byte.
REQ-006 req0_lock  input  1  requester 0 asks to keep ownership after the current byte.
REQ-007 req0_ready  output  1  byte accepted from requester 0 this cycle.
REQ-008 req1_valid, req1_data[7:0], req1_lock, req1_ready  same directions, widths and meanings as REQ-004..007, for requester 1.
REQ-009 uart_wr  output  1  one-cycle write strobe to the UART transmitter.
REQ-010 uart_dat  output  8  byte to transmit; valid while uart_wr=1.
REQ-011 uart_busy  input  1  UART transmitter busy; rises the cycle after uart_wr.
REQ-012 grant  output  2  one-hot current owner; 2'b00 when no owner.

Function
REQ-013 The arbiter SHALL use states IDLE, ISSUE, SETTLE and WAIT.
REQ-014 In IDLE with uart_busy=0, the arbiter SHALL combinationally assert readyN for exactly one requester with validN=1; at most one ready is high per cycle.
REQ-015 On validN & readyN at cycle T, the arbiter SHALL register the data into uart_dat, set grant to N, and enter ISSUE, so uart_wr=1 at T+1 only.
REQ-016 ISSUE SHALL last one cycle and go to SETTLE; SETTLE SHALL last one cycle, ignoring uart_busy, and go to WAIT.
REQ-017 WAIT SHALL return to IDLE on the first cycle uart_busy=0.
REQ-018 Ready SHALL be 0 in ISSUE, SETTLE and WAIT, and in IDLE whenever uart_busy=1.
REQ-019 Unlocked selection SHALL be round-robin: a 1-bit pointer names the last-served requester, and the other requester wins when both are valid.
REQ-020 After reset the pointer SHALL favour requester 0.
REQ-021 When the accepted byte had its lock input high and lock_cnt < LOCK_MAX, ownership SHALL be kept: grant stays set and only the owner may be readied in IDLE.
REQ-022 While the owner is locked and its valid is 0, the arbiter SHALL wait in IDLE; the other requester SHALL NOT be served, even if valid.
REQ-023 When the owner drops its lock in IDLE, it SHALL be released at once: grant=00 and normal round-robin resumes in the same cycle.
REQ-024 lock_cnt SHALL count bytes accepted from the current owner.
REQ-025 lock_cnt SHALL be 1 on the first byte of a new ownership.
REQ-026 lock_cnt SHALL saturate at LOCK_MAX.
REQ-027 lock_cnt SHALL clear when ownership is released.
REQ-028 When lock_cnt reaches LOCK_MAX, ownership SHALL be released regardless of lock, and the pointer SHALL favour the other requester.
REQ-029 After the forced release the previous owner may reacquire only when the other requester is not valid.
REQ-030 An unlocked byte SHALL release ownership on return to IDLE: grant=00.
REQ-031 Requester inputs SHALL be sampled only in IDLE; changes in other states SHALL have no effect.

Reset
REQ-032 With resetq=0 at a clock edge, all outputs SHALL become 0 on the next cycle: uart_wr=0, uart_dat=8'h00, req0_ready=req1_ready=0 and grant=2'b00.
REQ-033 Reset SHALL also set state=IDLE, lock_cnt=0 and pointer favouring requester 0.
REQ-034 Reset mid-transfer SHALL abandon the in-flight byte without a further uart_wr.
REQ-035 The first acceptance SHALL come no earlier than the first cycle after resetq returns high.

Verification
REQ-036 Single byte: req0 sends 8'hA5 with uart idle -> req0_ready at T, uart_wr=1 with uart_dat=A5 at T+1 only, grant=01 until WAIT exits, then grant=00.
REQ-037 Contention: both valid with unlocked bytes 8'h11/8'h22 repeatedly -> order 11,22,11,22; each uart_wr separated by a full UART frame, no strobe while uart_busy=1.
REQ-038 Lock hold: req1 locks and sends 3 bytes with req0 valid throughout -> all 3 req1 bytes go first, then req0; during the req1 valid gap, no req0_ready.
REQ-039 Forced release: LOCK_MAX=4, req0 locked and continuously valid, req1 valid -> 4 req0 bytes, 1 req1 byte, then req0 resumes with lock_cnt=1.
REQ-040 Reset mid-frame: resetq=0 in WAIT -> next cycle all outputs 0 and state IDLE; after release, a pending req1 is served first by pointer rule (req0 if both valid).
REQ-041 Settle window: uart_busy held low for 3 cycles after uart_wr (slow model) -> arbiter still spends exactly one cycle in SETTLE, returns to IDLE only on busy low, no double strobe.
